// File: rtl/multi_nch_disp_scan.sv
// N-channel display multiplexer: manual channel select or timed auto-scan, all outputs registered.
// Optional macro SCAN_MASK_EN: auto-scan skips channels whose ch_mask bit is clear.
module multi_nch_disp_scan #(
  parameter int CH    = 8,
  parameter int DW    = 32,
  parameter int PW    = 8,
  parameter int DWELL = 50000000,
  parameter int SELW  = $clog2(CH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               EN,
  input  logic               mode,
  input  logic [SELW-1:0]    Test,
  input  logic [CH*PW-1:0]   point_in,
  input  logic [CH*PW-1:0]   LES,
  input  logic [CH*DW-1:0]   data,
  input  logic [CH-1:0]      ch_mask,
  output logic [PW-1:0]      point_out,
  output logic [PW-1:0]      LE_out,
  output logic [DW-1:0]      Disp_num,
  output logic [SELW-1:0]    cur_ch,
  output logic               ch_strobe
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(DWELL - 1);
  localparam logic [SELW-1:0] LAST_CH = SELW'(CH - 1);

  typedef enum logic {MANUAL, AUTO} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [SELW-1:0] r_cur_ch;
  logic [PW-1:0]   r_point;
  logic [PW-1:0]   r_le;
  logic [DW-1:0]   r_disp;
  logic            r_strobe;

  state_t          w_next_state;
  logic [CW-1:0]   w_next_cnt;
  logic [SELW-1:0] w_next_ch;
  logic [SELW-1:0] w_adv_ch;
  logic [SELW-1:0] w_test_ch;

  assign w_test_ch = (int'(Test) >= CH) ? LAST_CH : Test;

  // Channel the auto-scan moves to when the dwell period expires.
`ifdef SCAN_MASK_EN
  always_comb begin : adv_sel
    int   idx;
    logic found;
    w_adv_ch = r_cur_ch;
    found    = 1'b0;
    idx      = 0;
    for (int k = 1; k <= CH; k++) begin
      idx = int'(r_cur_ch) + k;
      if (idx >= CH) idx = idx - CH;
      if (!found && ch_mask[idx]) begin
        found    = 1'b1;
        w_adv_ch = SELW'(idx);
      end
    end
  end
`else
  logic w_unused_mask;
  assign w_unused_mask = ^ch_mask;
  assign w_adv_ch = (r_cur_ch == LAST_CH) ? '0 : r_cur_ch + SELW'(1);
`endif

  // A mode change always takes priority over dwell expiry and holds the channel.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_ch    = r_cur_ch;
    case (r_state)
      MANUAL: begin
        w_next_cnt = '0;
        if (mode) w_next_state = AUTO;
        else      w_next_ch    = w_test_ch;
      end
      AUTO: begin
        if (!mode) begin
          w_next_state = MANUAL;
          w_next_cnt   = '0;
        end else if (r_cnt == CNT_MAX) begin
          w_next_cnt = '0;
          w_next_ch  = w_adv_ch;
        end else begin
          w_next_cnt = r_cnt + CW'(1);
        end
      end
      default: w_next_state = MANUAL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= MANUAL;
      r_cnt    <= '0;
      r_cur_ch <= '0;
      r_point  <= '0;
      r_le     <= '0;
      r_disp   <= '0;
      r_strobe <= 1'b0;
    end else if (EN) begin
      r_state  <= w_next_state;
      r_cnt    <= w_next_cnt;
      r_cur_ch <= w_next_ch;
      r_point  <= point_in[w_next_ch*PW +: PW];
      r_le     <= LES[w_next_ch*PW +: PW];
      r_disp   <= data[w_next_ch*DW +: DW];
      r_strobe <= (w_next_ch != r_cur_ch);
    end else begin
      r_strobe <= 1'b0;
    end
  end

  assign point_out = r_point;
  assign LE_out    = r_le;
  assign Disp_num  = r_disp;
  assign cur_ch    = r_cur_ch;
  assign ch_strobe = r_strobe;

endmodule

// File: tb/tb_multi_nch_disp_scan.sv
// Directed bench for multi_nch_disp_scan: an 8-channel scanner (DWELL=4) and a 6-channel one for clamping.
module tb_multi_nch_disp_scan;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic EN  = 1'b1;

  logic          modeA = 1'b0;
  logic [2:0]    testA = '0;
  logic [63:0]   pointA, lesA;
  logic [255:0]  dataA;
  logic [7:0]    maskA = 8'hFF;
  logic [7:0]    pointOutA, leOutA;
  logic [31:0]   dispA;
  logic [2:0]    curA;
  logic          strobeA;

  logic          modeB = 1'b0;
  logic [2:0]    testB = '0;
  logic [47:0]   pointB, lesB;
  logic [191:0]  dataB;
  logic [7:0]    pointOutB, leOutB;
  logic [31:0]   dispB;
  logic [2:0]    curB;
  logic          strobeB;

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk = ~clk;

  multi_nch_disp_scan #(.CH(8), .DW(32), .PW(8), .DWELL(4)) u_dutA (
    .clk(clk), .rst(rst), .EN(EN), .mode(modeA), .Test(testA),
    .point_in(pointA), .LES(lesA), .data(dataA), .ch_mask(maskA),
    .point_out(pointOutA), .LE_out(leOutA), .Disp_num(dispA),
    .cur_ch(curA), .ch_strobe(strobeA)
  );

  multi_nch_disp_scan #(.CH(6), .DW(32), .PW(8), .DWELL(3)) u_dutB (
    .clk(clk), .rst(rst), .EN(EN), .mode(modeB), .Test(testB),
    .point_in(pointB), .LES(lesB), .data(dataB), .ch_mask(6'h3F),
    .point_out(pointOutB), .LE_out(leOutB), .Disp_num(dispB),
    .cur_ch(curB), .ch_strobe(strobeB)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic m, input logic [2:0] t);
    modeA = m;
    testA = t;
  endtask

  initial begin
    dataA = {32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 32'h00000000,
             32'hAA5555AA, 32'h55AAAA55, 32'h87654321, 32'h12345678};
    for (int i = 0; i < 8; i++) begin
      pointA[i*8 +: 8] = 8'h10 + 8'(i);
      lesA[i*8 +: 8]   = 8'hA0 + 8'(i);
    end
    for (int i = 0; i < 6; i++) begin
      dataB[i*32 +: 32] = 32'h1000_0000 + 32'(i);
      pointB[i*8 +: 8]  = 8'h30 + 8'(i);
      lesB[i*8 +: 8]    = 8'hC0 + 8'(i);
    end

    // Reset state, before any clock edge
    #3;
    checkOutput("reset_disp", dispA, 0);
    checkOutput("reset_cur", curA, 0);
    checkOutput("reset_strobe", strobeA, 0);
    checkOutput("reset_point", pointOutA, 0);
    #3 rst = 1'b1;

    // Manual select
    tick(1);
    checkOutput("man_ch0_disp", dispA, 32'h12345678);
    checkOutput("man_ch0_nostrobe", strobeA, 0);
    applyStimulus(1'b0, 3'd2);
    testB = 3'd7;
    tick(1);
    checkOutput("man_ch2_cur", curA, 2);
    checkOutput("man_ch2_disp", dispA, 32'h55AAAA55);
    checkOutput("man_ch2_point", pointOutA, 8'h12);
    checkOutput("man_ch2_le", leOutA, 8'hA2);
    checkOutput("man_ch2_strobe", strobeA, 1);
    checkOutput("clamp_cur", curB, 5);
    checkOutput("clamp_disp", dispB, 32'h1000_0005);
    checkOutput("clamp_le", leOutB, 8'hC5);
    tick(1);
    checkOutput("man_strobe_once", strobeA, 0);

    // Live data tracking without a channel change
    dataA[2*32 +: 32] = 32'hDEADBEEF;
    dataB[5*32 +: 32] = 32'hCAFEF00D;
    testB = 3'd6;
    tick(1);
    checkOutput("live_disp", dispA, 32'hDEADBEEF);
    checkOutput("live_nostrobe", strobeA, 0);
    checkOutput("live_clamp_disp", dispB, 32'hCAFEF00D);
    checkOutput("live_clamp_cur", curB, 5);
    checkOutput("live_clamp_nostrobe", strobeB, 0);
    dataA[2*32 +: 32] = 32'h55AAAA55;

    // Auto scan from channel 0, full wrap
    applyStimulus(1'b0, 3'd0);
    tick(1);
    checkOutput("pre_auto_cur", curA, 0);
    applyStimulus(1'b1, 3'd5);
    tick(1);
    checkOutput("auto_entry_cur", curA, 0);
    tick(3);
    checkOutput("auto_dwell_cur", curA, 0);
    for (int s = 1; s <= 8; s++) begin
      tick(1);
      checkOutput($sformatf("auto_step%0d_cur", s), curA, 64'(s % 8));
      checkOutput($sformatf("auto_step%0d_strobe", s), strobeA, 1);
      if (s < 8) begin
        tick(3);
        checkOutput($sformatf("auto_step%0d_hold", s), strobeA, 0);
      end
    end
    checkOutput("auto_wrap_disp", dispA, 32'h12345678);

    // Freeze mid-dwell at count 2
    tick(2);
    EN = 1'b0;
    dataA[0 +: 32] = 32'h0BADF00D;
    tick(10);
    checkOutput("freeze_cur", curA, 0);
    checkOutput("freeze_disp", dispA, 32'h12345678);
    checkOutput("freeze_strobe", strobeA, 0);
    dataA[0 +: 32] = 32'h12345678;
    EN = 1'b1;
    tick(1);
    checkOutput("resume_cur_hold", curA, 0);
    tick(1);
    checkOutput("resume_cur_adv", curA, 1);
    checkOutput("resume_strobe", strobeA, 1);
    checkOutput("resume_disp", dispA, 32'h87654321);

    // Mode change coinciding with dwell expiry
    tick(3);
    applyStimulus(1'b0, 3'd1);
    tick(1);
    checkOutput("modechg_cur", curA, 1);
    checkOutput("modechg_nostrobe", strobeA, 0);
    applyStimulus(1'b0, 3'd5);
    tick(1);
    checkOutput("manual_again_cur", curA, 5);
    checkOutput("manual_again_disp", dispA, 32'hFFFFFFFF);

    // Asynchronous reset between edges during auto scan
    applyStimulus(1'b1, 3'd3);
    tick(6);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_disp", dispA, 0);
    checkOutput("async_cur", curA, 0);
    checkOutput("async_le", leOutA, 0);
    checkOutput("async_strobe", strobeA, 0);
    applyStimulus(1'b0, 3'd3);
    #1 rst = 1'b1;
    tick(1);
    checkOutput("post_reset_cur", curA, 3);
    checkOutput("post_reset_disp", dispA, 32'hAA5555AA);
    checkOutput("post_reset_strobe", strobeA, 1);

`ifdef SCAN_MASK_EN
    // Masked scan: 0 -> 2 -> 7 -> 0, then an empty mask holds
    applyStimulus(1'b0, 3'd0);
    tick(1);
    maskA = 8'b1000_0101;
    applyStimulus(1'b1, 3'd0);
    tick(1);
    tick(4);
    checkOutput("mask_step1", curA, 2);
    tick(4);
    checkOutput("mask_step2", curA, 7);
    tick(4);
    checkOutput("mask_step3", curA, 0);
    maskA = 8'b0;
    tick(1);
    tick(8);
    checkOutput("mask_empty_cur", curA, 0);
    checkOutput("mask_empty_strobe", strobeA, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
